// File: rtl/sort_engine.sv
// sort_engine: buffers one frame, sorts it in place by odd-even transposition
// (one phase per cycle), then streams the sorted words out under ready/valid.
module sort_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              descend,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              ovf
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = CNT_W - 1;

    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, phase_q, phase_d, rd_idx_q, rd_idx_d, rd_nxt;
    logic              desc_q, desc_d, ovf_q, ovf_d, busy_q, busy_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d       = mem_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        rd_idx_d    = rd_idx_q;
        desc_d      = desc_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        rd_nxt      = rd_idx_q + 1'b1;
        case (state_q)
            IDLE: if (in_valid) begin
                mem_d[0] = in_data;
                cnt_d    = CNT_W'(1);
                desc_d   = descend;
                ovf_d    = 1'b0;
                state_d  = LOAD;
            end
            LOAD: if (!in_valid) begin
                state_d = SORT;
                phase_d = '0;
                busy_d  = 1'b1;
            end else if (cnt_q < CNT_W'(DEPTH)) begin
                mem_d[cnt_q[IDX_W-1:0]] = in_data;
                cnt_d = cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
            SORT: begin
                // Pairs in one phase are disjoint, so every swap reads only mem_q.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (i[0] == phase_q[0] && CNT_W'(i + 1) < cnt_q &&
                        (desc_q ? mem_q[i] < mem_q[i+1] : mem_q[i] > mem_q[i+1])) begin
                        mem_d[i]   = mem_q[i+1];
                        mem_d[i+1] = mem_q[i];
                    end
                end
                phase_d = phase_q + 1'b1;
                if (phase_q == cnt_q - 1'b1) begin
                    state_d     = OUT;
                    rd_idx_d    = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = mem_d[0];
                    out_last_d  = (cnt_q == CNT_W'(1));
                end
            end
            OUT: if (out_ready) begin
                if (out_last_q) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    phase_d     = '0;
                    rd_idx_d    = '0;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_last_d  = 1'b0;
                end else begin
                    rd_idx_d   = rd_nxt;
                    out_data_d = mem_q[rd_nxt[IDX_W-1:0]];
                    out_last_d = (rd_nxt == cnt_q - 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            rd_idx_q    <= '0;
            desc_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            rd_idx_q    <= rd_idx_d;
            desc_q      <= desc_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed frames with hand-computed sorted results, checked
// by immediate assertions as each output word is accepted.
module tb_sort_engine;
    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, descend = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_valid, out_last, busy, ovf;
    logic [7:0] out_data;
    int         checks = 0, errors = 0, cyc = 0;
    int         din [0:511];
    int         exp_a [0:511];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .descend(descend), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // descend is flipped after the first word: only the first word may set direction
    task automatic send(input int n, input logic d);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(din[k]);
            descend  = (k == 0) ? d : ~d;
            step();
            if (k == 0) chk("busy_load", busy, 0);
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic recv(input int n, input int mode);
        int idx = 0, guard = 0, first = 0, last = 0;
        logic [7:0] held = 8'd0;
        logic stalled = 1'b0;
        while (idx < n && guard < 5000) begin
            out_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (stalled) chk("stall_hold", out_data, held);
                if (out_ready) begin
                    chk("data", out_data, exp_a[idx]);
                    chk("last", out_last, (idx == n - 1) ? 1 : 0);
                    if (idx == 0) first = cyc;
                    last = cyc;
                    idx++;
                    stalled = 1'b0;
                end else begin
                    held    = out_data;
                    stalled = 1'b1;
                end
            end
            step();
            guard++;
        end
        out_ready = 1'b0;
        chk("recv_count", idx, n);
        if (mode == 0) chk("consecutive", last - first, n - 1);
        chk("valid_after", out_valid, 0);
        chk("data_idle", out_data, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        step();

        // two-word frame, latency check
        din[0] = 0; din[1] = 1;
        send(2, 1'b1);
        chk("lat_load", out_valid, 0);
        step();
        chk("lat_busy", busy, 1);
        chk("lat_e0", out_valid, 0);
        step();
        chk("lat_e1", out_valid, 0);
        step();
        chk("lat_e2", out_valid, 1);
        chk("lat_data", out_data, 1);
        chk("lat_last", out_last, 0);
        exp_a[0] = 1; exp_a[1] = 0;
        recv(2, 0);

        for (int k = 0; k < 256; k++) begin din[k] = k; exp_a[k] = 255 - k; end
        send(256, 1'b1);
        recv(256, 0);
        chk("ovf_full_desc", ovf, 0);

        for (int k = 0; k < 256; k++) exp_a[k] = k;
        send(256, 1'b0);
        recv(256, 0);
        chk("ovf_full_asc", ovf, 0);

        din[0] = 7; exp_a[0] = 7;
        send(1, 1'b0);
        recv(1, 0);

        // DEPTH+1 words: trailing 77 must be dropped
        for (int k = 0; k < 256; k++) begin din[k] = 255 - k; exp_a[k] = k; end
        din[256] = 77;
        send(257, 1'b0);
        chk("ovf_set", ovf, 1);
        recv(256, 0);
        chk("ovf_sticky", ovf, 1);
        din[0] = 3; exp_a[0] = 3;
        send(1, 1'b1);
        chk("ovf_cleared", ovf, 0);
        recv(1, 0);

        din[0] = 5; din[1] = 3; din[2] = 9; din[3] = 3;
        din[4] = 0; din[5] = 255; din[6] = 128; din[7] = 7;
        exp_a[0] = 0; exp_a[1] = 3; exp_a[2] = 3; exp_a[3] = 5;
        exp_a[4] = 7; exp_a[5] = 9; exp_a[6] = 128; exp_a[7] = 255;
        send(8, 1'b0);
        recv(8, 1);
        exp_a[0] = 255; exp_a[1] = 128; exp_a[2] = 9; exp_a[3] = 7;
        exp_a[4] = 5; exp_a[5] = 3; exp_a[6] = 3; exp_a[7] = 0;
        send(8, 1'b1);
        recv(8, 1);

        // reset in the middle of SORT
        din[0] = 4; din[1] = 1; din[2] = 3; din[3] = 2;
        send(4, 1'b1);
        step();
        step();
        chk("mid_sort_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("async_busy", busy, 0);
        chk("async_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'b1;
            step();
            chk("no_stale", out_valid, 0);
        end
        din[0] = 2; din[1] = 1; exp_a[0] = 1; exp_a[1] = 2;
        send(2, 1'b0);
        recv(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sort_engine.md
SORT_ENGINE -- requirements
Module: sort_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits (range 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the maximum words per frame (range 2..1024).
REQ-003 The block SHALL have derived parameter CNT_W, default $clog2(DEPTH)+1, meaning the count width; it SHALL NOT be overridden.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: high on each cycle carrying a frame word; a frame is one contiguous run of in_valid high.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: unsigned word, sampled when in_valid=1.
REQ-008 The block SHALL have port descend, input, 1 bit: 1 = largest first, 0 = smallest first; sampled on the first word of a frame only.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accept.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a sorted word.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: sorted word.
REQ-012 The block SHALL have port out_last, output, 1 bit: high with the final word of the frame.
REQ-013 The block SHALL have port busy, output, 1 bit: high in SORT and OUT.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky flag meaning the frame exceeded DEPTH words; cleared at the start of the next frame.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD, SORT, OUT.
REQ-016 In IDLE, when in_valid=1, the block SHALL store word 0, set cnt=1, latch descend, clear ovf, and go to LOAD.
REQ-017 In LOAD, when in_valid=1 and cnt<DEPTH, the block SHALL store the word at index cnt and increment cnt.
REQ-018 In LOAD, when in_valid=1 and cnt==DEPTH, the block SHALL drop the word and set ovf=1.
REQ-019 In LOAD, when in_valid=0, the block SHALL go to SORT with phase=0.
REQ-020 In SORT, the block SHALL perform one odd-even transposition phase per cycle: even phases compare pairs (i,i+1) for even i, odd phases for odd i, and only pairs with i+1<cnt are compared.
REQ-021 A pair SHALL swap only if strictly out of order for the latched direction; equal values SHALL NOT swap.
REQ-022 After exactly cnt phases the block SHALL go to OUT; for cnt=1, one idle phase SHALL occur.
REQ-023 out_valid SHALL first be high in the cycle following the cnt-th rising edge after the edge that sampled in_valid=0.
REQ-024 In OUT, out_valid=1 and out_data=word[rd_idx]; a transfer SHALL occur when out_valid&&out_ready, and each transfer SHALL increment rd_idx.
REQ-025 While out_ready=0, out_data SHALL hold stable.
REQ-026 out_last SHALL equal (rd_idx==cnt-1) while in OUT.
REQ-027 After the last transfer, the block SHALL go to IDLE, with out_valid=0 in the next cycle.
REQ-028 in_valid in SORT or OUT SHALL be ignored, with no state change.
REQ-029 A new frame MAY start in the first cycle of IDLE.
REQ-030 Outside OUT, out_data SHALL be 0.
REQ-031 busy=0 in IDLE and LOAD.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously force state=IDLE, cnt=0, rd_idx=0, phase=0, out_valid=0, out_data=0, out_last=0, busy=0, ovf=0.
REQ-033 Reset mid-LOAD, SORT or OUT SHALL discard the frame; no output words SHALL follow reset release.
REQ-034 Word storage need not be reset.

Verification
REQ-035 2-word frame {0,1}, descend=1, out_ready=1 -> out_valid high 2 cycles after in_valid falls, outputs 1 then 0, out_last on 0.
REQ-036 256 words 0..255, descend=1, DEPTH=256 -> outputs 255..0 on 256 consecutive cycles, ovf=0.
REQ-037 Same 256 words with descend=0 -> outputs 0..255; 1-word frame {7} -> single output 7 with out_last=1.
REQ-038 DEPTH+1 words -> ovf=1, exactly DEPTH words sorted and output, last input dropped.
REQ-039 Random frame, out_ready toggled randomly -> correct sorted sequence, out_data stable while stalled, no drop or duplication.
REQ-040 rst_n pulsed low mid-SORT, then a new frame sent -> no stale output, only the new frame's sorted result.
